// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared types, segment lookup table and helpers for the multiplexed
// 7-segment scan driver.
package seven_seg_scan_driver_pkg;

`include "seven_seg_defs.vh"

  typedef logic [6:0] seg_pat_t;

  localparam logic [7:0] SEG_BLANK_C = `SEG_BLANK;

  // Entry 0 sits at the right-hand end so SEG_HEX[nibble] selects directly.
  localparam logic [15:0][6:0] SEG_HEX = {
    `SEG_PAT_F, `SEG_PAT_E, `SEG_PAT_D, `SEG_PAT_C,
    `SEG_PAT_B, `SEG_PAT_A, `SEG_PAT_9, `SEG_PAT_8,
    `SEG_PAT_7, `SEG_PAT_6, `SEG_PAT_5, `SEG_PAT_4,
    `SEG_PAT_3, `SEG_PAT_2, `SEG_PAT_1, `SEG_PAT_0
  };

  function automatic logic [7:0] seg_compose(input seg_pat_t pat, input logic dp_on);
    logic [7:0] s;
    s = {1'b1, pat};
    s[`SEG_BIT_DP] = ~dp_on;
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_defs.vh
// Active-low 7-segment patterns (g..a) and segment bit positions shared by the
// scan driver package.
`ifndef SEVEN_SEG_DEFS_VH
`define SEVEN_SEG_DEFS_VH

`define SEG_PAT_0 7'b1000000
`define SEG_PAT_1 7'b1111001
`define SEG_PAT_2 7'b0100100
`define SEG_PAT_3 7'b0110000
`define SEG_PAT_4 7'b0011001
`define SEG_PAT_5 7'b0010010
`define SEG_PAT_6 7'b0000010
`define SEG_PAT_7 7'b1111000
`define SEG_PAT_8 7'b0000000
`define SEG_PAT_9 7'b0010000
`define SEG_PAT_A 7'b0001000
`define SEG_PAT_B 7'b0000011
`define SEG_PAT_C 7'b1000110
`define SEG_PAT_D 7'b0100001
`define SEG_PAT_E 7'b0000110
`define SEG_PAT_F 7'b0001110

`define SEG_BLANK 8'hFF

`define SEG_BIT_A  0
`define SEG_BIT_B  1
`define SEG_BIT_C  2
`define SEG_BIT_D  3
`define SEG_BIT_E  4
`define SEG_BIT_F  5
`define SEG_BIT_G  6
`define SEG_BIT_DP 7

`endif

// File: rtl/seven_seg_scan_driver_hex_seg_lut.sv
// Combinational hex nibble to active-low g..a segment pattern lookup.
module hex_seg_lut
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] nib,
  output seg_pat_t   pat
);

  always_comb begin
    pat = SEG_HEX[nib];
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one digit per slot, blank
// lead-in per slot, display buffer swapped only at frame boundaries.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   Dp,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   En_Mask,
  input  logic                    Lz_Sup,
  output logic [7:0]              Seg,
  output logic [NUM_DIGITS-1:0]   An,
  output logic                    Frame_Done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    pend_valid;

  logic                    slot_end;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_en;
  logic                    sel_supp;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_lit;
  seg_pat_t                sel_pat;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A Load on the boundary cycle bypasses the pending buffer so it is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else if (frame_end) begin
      pend_valid <= 1'b0;
      if (Load) begin
        disp_val <= Value;
        disp_dp  <= Dp;
      end else if (pend_valid) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
    end else if (Load) begin
      pend_val   <= Value;
      pend_dp    <= Dp;
      pend_valid <= 1'b1;
    end
  end

  // Suppression runs down from the most significant digit and stops at the first
  // non-blank digit; digit 0 always shows.
  always_comb begin
    logic run;
    supp = '0;
    run  = Lz_Sup;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run     = run && (disp_val[4*i +: 4] == 4'h0) && !disp_dp[i];
      supp[i] = run;
    end
  end

  always_comb begin
    sel_nib  = '0;
    sel_dp   = 1'b0;
    sel_en   = 1'b0;
    sel_supp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_nib  = disp_val[4*i +: 4];
        sel_dp   = disp_dp[i];
        sel_en   = En_Mask[i];
        sel_supp = supp[i];
      end
    end
  end

  assign an_lit = ~(NUM_DIGITS'(1) << idx);
  assign lit    = sel_en && !sel_supp && (cnt >= CNT_BLANK);

  hex_seg_lut u_lut (
    .nib (sel_nib),
    .pat (sel_pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Seg        <= SEG_BLANK_C;
      An         <= '1;
      Frame_Done <= 1'b0;
    end else begin
      Frame_Done <= frame_end;
      if (lit) begin
        Seg <= seg_compose(sel_pat, sel_dp);
        An  <= an_lit;
      end else begin
        Seg <= SEG_BLANK_C;
        An  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with 4 digits, 8-cycle slots and
// 2 blank cycles per slot.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Value;
  logic [3:0]  Dp;
  logic        Load;
  logic [3:0]  En_Mask;
  logic        Lz_Sup;
  logic [7:0]  Seg;
  logic [3:0]  An;
  logic        Frame_Done;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        lz;
    logic [3:0]  lit;
    logic [31:0] seg;
  } vec_t;

  vec_t vecs [8];

  seven_seg_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Value      (Value),
    .Dp         (Dp),
    .Load       (Load),
    .En_Mask    (En_Mask),
    .Lz_Sup     (Lz_Sup),
    .Seg        (Seg),
    .An         (An),
    .Frame_Done (Frame_Done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    En_Mask = v.mask;
    Lz_Sup  = v.lz;
    Value   = v.value;
    Dp      = v.dp;
    Load    = 1'b1;
    tick();
    Load    = 1'b0;
  endtask

  task automatic waitFrame(input string name);
    int n;
    n = 0;
    while (!Frame_Done && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, " frame wait"}, {31'h0, Frame_Done}, 32'h1);
  endtask

  // Plays one full frame starting right after a boundary sample; optional Load
  // pulses are issued on the edges at positions ld_pos1/ld_pos2 (1..32).
  task automatic runFrame(input string name, input logic [3:0] lit, input logic [31:0] seg,
                          input int ld_pos1, input logic [15:0] ld_val1,
                          input int ld_pos2, input logic [15:0] ld_val2);
    logic [31:0] fd_bits;
    int          multi_low;
    fd_bits   = '0;
    multi_low = 0;
    for (int s = 0; s < 4; s++) begin
      logic [11:0] first_act;
      logic [11:0] first_exp;
      logic        bad;
      bad       = 1'b0;
      first_act = '0;
      first_exp = '0;
      for (int c = 0; c < 8; c++) begin
        int         p;
        logic [3:0] ea;
        logic [7:0] es;
        p = s * 8 + c + 1;
        if (p == ld_pos1) begin
          Value = ld_val1; Dp = 4'h0; Load = 1'b1;
        end else if (p == ld_pos2) begin
          Value = ld_val2; Dp = 4'h0; Load = 1'b1;
        end
        tick();
        Load = 1'b0;
        if (c < 2 || !lit[s]) begin
          ea = 4'hF;
          es = 8'hFF;
        end else begin
          ea = ~(4'b0001 << s);
          es = seg[8*s +: 8];
        end
        fd_bits[p-1] = Frame_Done;
        if ($countones(~An) > 1) multi_low++;
        if (!bad) begin
          first_act = {An, Seg};
          first_exp = {ea, es};
          if ({An, Seg} !== {ea, es}) bad = 1'b1;
        end
      end
      checkOutput($sformatf("%s slot%0d {An,Seg}", name, s), {20'h0, first_act}, {20'h0, first_exp});
    end
    checkOutput({name, " Frame_Done pattern"}, fd_bits, 32'h8000_0000);
    checkOutput({name, " one-hot An"}, multi_low, 0);
  endtask

  initial begin
    // {value, dp, mask, lz, lit digits, Seg per digit d3..d0 (FF = dark)}
    vecs[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 4'b1111, 32'hF9A4_888E};
    vecs[1] = '{16'h0070, 4'h0, 4'hF, 1'b1, 4'b0011, 32'hFFFF_F8C0};
    vecs[2] = '{16'h0070, 4'h4, 4'hF, 1'b1, 4'b0111, 32'hFF40_F8C0};
    vecs[3] = '{16'h8888, 4'h0, 4'h5, 1'b0, 4'b0101, 32'hFF80_FF80};
    vecs[4] = '{16'h0000, 4'h0, 4'hF, 1'b1, 4'b0001, 32'hFFFF_FFC0};
    vecs[5] = '{16'h3456, 4'hF, 4'hF, 1'b1, 4'b1111, 32'h3019_1202};
    vecs[6] = '{16'h0B0D, 4'h0, 4'hF, 1'b1, 4'b0111, 32'hFF83_C0A1};
    vecs[7] = '{16'h9E0C, 4'h1, 4'hF, 1'b0, 4'b1111, 32'h9086_C046};

    rst = 1'b1; Load = 1'b0; Value = '0; Dp = '0; En_Mask = 4'hF; Lz_Sup = 1'b0;
    tick();
    tick();
    checkOutput("reset Seg", {24'h0, Seg}, 32'hFF);
    checkOutput("reset An", {28'h0, An}, 32'hF);
    checkOutput("reset Frame_Done", {31'h0, Frame_Done}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      waitFrame($sformatf("vec%0d", i));
      runFrame($sformatf("vec%0d", i), vecs[i].lit, vecs[i].seg, 0, '0, 0, '0);
    end

    $display("[TB] free-running frames");
    runFrame("freerun0", vecs[7].lit, vecs[7].seg, 0, '0, 0, '0);
    runFrame("freerun1", vecs[7].lit, vecs[7].seg, 0, '0, 0, '0);

    $display("[TB] two loads within one frame, last one wins at the boundary");
    runFrame("during loads", vecs[7].lit, vecs[7].seg, 3, 16'h0056, 10, 16'h0078);
    runFrame("after loads", 4'hF, 32'hC0C0_F880, 0, '0, 0, '0);
    runFrame("boundary load", 4'hF, 32'hC0C0_F880, 32, 16'h1234, 0, '0);
    checkOutput("boundary load pend_valid", {31'h0, dut.pend_valid}, 32'h0);
    runFrame("after boundary load", 4'hF, 32'hF9A4_B099, 0, '0, 0, '0);

    $display("[TB] reset mid-slot of digit 2 with a pending load");
    for (int p = 1; p <= 20; p++) begin
      if (p == 5) begin
        Value = 16'h4321; Dp = 4'h0; Load = 1'b1;
      end
      tick();
      Load = 1'b0;
    end
    rst = 1'b1;
    tick();
    checkOutput("midreset Seg", {24'h0, Seg}, 32'hFF);
    checkOutput("midreset An", {28'h0, An}, 32'hF);
    checkOutput("midreset Frame_Done", {31'h0, Frame_Done}, 32'h0);
    checkOutput("midreset cnt", {29'h0, dut.cnt}, 32'h0);
    checkOutput("midreset idx", {30'h0, dut.idx}, 32'h0);
    checkOutput("midreset display buffer", {16'h0, dut.disp_val}, 32'h0);
    checkOutput("midreset pend_valid", {31'h0, dut.pend_valid}, 32'h0);
    rst = 1'b0;
    runFrame("post-reset0", 4'hF, 32'hC0C0_C0C0, 0, '0, 0, '0);
    runFrame("post-reset1", 4'hF, 32'hC0C0_C0C0, 0, '0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
